// File: rtl/instruction_fetch.sv
// IF stage: program counter, req/ack instruction-memory reads, one-entry park
// buffer for responses that land during a load-use stall, and squash of stale reads.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lw_hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [31:0] PC_IF,
  output logic        valid_IF
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] stale_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  always_comb begin
    pc_plus4  = pc + 32'd4;
    imem_req  = (state == FETCH) || (state == DROP);
    imem_addr = (state == DROP) ? stale_addr : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      stale_addr     <= '0;
      buf_instr      <= '0;
      buf_pc         <= '0;
      instruction_IF <= '0;
      PC_IF          <= '0;
      valid_IF       <= 1'b0;
    end else begin
      // Default output action: bubble unless stalled; branches always bubble.
      // Loads of a real instruction below override this.
      if (branch_taken || !lw_hazard) begin
        instruction_IF <= '0;
        valid_IF       <= 1'b0;
      end

      case (state)
        IDLE: begin
          state <= FETCH;
          if (branch_taken) pc <= branch_target;
        end

        FETCH: begin
          if (branch_taken) begin
            pc <= branch_target;
            if (!imem_ack) begin
              stale_addr <= pc;
              state      <= DROP;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (lw_hazard) begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc_plus4;
              state     <= HOLD;
            end else begin
              instruction_IF <= imem_rdata;
              PC_IF          <= pc_plus4;
              valid_IF       <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (branch_taken) begin
            pc    <= branch_target;
            state <= FETCH;
          end else if (!lw_hazard) begin
            instruction_IF <= buf_instr;
            PC_IF          <= buf_pc;
            valid_IF       <= 1'b1;
            state          <= FETCH;
          end
        end

        DROP: begin
          // The stale read keeps the bus until acked; a branch only retargets pc.
          if (branch_taken) pc <= branch_target;
          if (imem_ack) state <= FETCH;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch, checked against a
// flag-based behavioural model of the fetch stage.
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lw_hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_IF;
  logic [31:0] PC_IF;
  logic        valid_IF;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lw_hazard      (lw_hazard),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruction_IF (instruction_IF),
    .PC_IF          (PC_IF),
    .valid_IF       (valid_IF)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed nonzero-ish function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model state
  bit          m_started;
  bit          m_stale_pending;
  bit          m_parked;
  logic [31:0] m_pc, m_stale, m_pk_instr, m_pk_pc;
  logic [31:0] m_instr, m_pcif;
  bit          m_valid;

  task automatic model_reset();
    m_started = 0; m_stale_pending = 0; m_parked = 0;
    m_pc = RPC; m_stale = '0; m_pk_instr = '0; m_pk_pc = '0;
    m_instr = '0; m_pcif = '0; m_valid = 0;
  endtask

  task automatic model_step(input bit lw, input bit br, input logic [31:0] tgt, input bit ack);
    logic [31:0] word;
    if (br || !lw) begin m_instr = '0; m_valid = 0; end
    if (!m_started) begin
      m_started = 1;
      if (br) m_pc = tgt;
    end else if (m_parked) begin
      if (br) begin
        m_parked = 0; m_pc = tgt;
      end else if (!lw) begin
        m_parked = 0; m_instr = m_pk_instr; m_pcif = m_pk_pc; m_valid = 1;
      end
    end else if (m_stale_pending) begin
      if (br) m_pc = tgt;
      if (ack) m_stale_pending = 0;
    end else if (br) begin
      if (!ack) begin m_stale = m_pc; m_stale_pending = 1; end
      m_pc = tgt;
    end else if (ack) begin
      word = mem_word(m_pc);
      m_pc = m_pc + 32'd4;
      if (lw) begin
        m_parked = 1; m_pk_instr = word; m_pk_pc = m_pc;
      end else begin
        m_instr = word; m_pcif = m_pc; m_valid = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, m_started && !m_parked});
    chk({tag, ".addr"},  imem_addr, m_stale_pending ? m_stale : m_pc);
    chk({tag, ".instr"}, instruction_IF, m_instr);
    chk({tag, ".pcif"},  PC_IF, m_pcif);
    chk({tag, ".valid"}, {31'd0, valid_IF}, {31'd0, m_valid});
  endtask

  // Called at a negedge: drive inputs for the coming edge, advance model, check at next negedge.
  task automatic step(input string tag, input bit lw, input bit br, input logic [31:0] tgt, input bit ack);
    lw_hazard = lw; branch_taken = br; branch_target = tgt; imem_ack = ack;
    imem_rdata = mem_word(imem_addr);
    model_step(lw, br, tgt, ack);
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_all("reset_rel");
  endtask

  initial begin
    lw_hazard = 0; branch_taken = 0; branch_target = '0; imem_ack = 0; imem_rdata = '0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Zero-wait stream from RESET_PC
    step("zw0", 0, 0, '0, 1);
    chk("zw_addr0", imem_addr, 32'h100);
    step("zw1", 0, 0, '0, 1);
    chk("zw_addr1", imem_addr, 32'h104);
    chk("zw_pcif1", PC_IF, 32'h104);
    step("zw2", 0, 0, '0, 1);
    chk("zw_pcif2", PC_IF, 32'h108);
    chk("zw_valid2", {31'd0, valid_IF}, 32'd1);
    step("zw3", 0, 0, '0, 1);

    // Two wait states per read
    for (int unsigned i = 0; i < 3; i++) begin
      step("w2a", 0, 0, '0, 0);
      chk("w2_bubble", {31'd0, valid_IF}, 32'd0);
      step("w2b", 0, 0, '0, 0);
      step("w2c", 0, 0, '0, 1);
    end

    // Ack under a 3-cycle load-use stall
    step("st0", 1, 0, '0, 1);
    chk("st_req", {31'd0, imem_req}, 32'd0);
    step("st1", 1, 0, '0, 1);
    step("st2", 1, 0, '0, 0);
    step("st_rel", 0, 0, '0, 0);
    chk("st_valid", {31'd0, valid_IF}, 32'd1);
    step("st_next", 0, 0, '0, 1);

    // Branch to 0x400 while a read of 0x20 is pending
    step("b20", 0, 1, 32'h20, 1);
    step("b400", 0, 1, 32'h400, 0);
    chk("drop_addr0", imem_addr, 32'h20);
    step("drop1", 0, 0, '0, 0);
    chk("drop_addr1", imem_addr, 32'h20);
    step("drop_ack", 0, 0, '0, 1);
    chk("drop_noval", {31'd0, valid_IF}, 32'd0);
    chk("drop_next", imem_addr, 32'h400);
    step("tgt", 0, 0, '0, 1);
    chk("tgt_pcif", PC_IF, 32'h404);

    // Branch together with stall while holding a parked word
    step("h0", 1, 0, '0, 1);
    step("hbr", 1, 1, 32'h800, 0);
    chk("hbr_valid", {31'd0, valid_IF}, 32'd0);
    chk("hbr_addr", imem_addr, 32'h800);

    // Wrap of pc+4
    step("wrapb", 0, 1, 32'hFFFF_FFFC, 1);
    step("wrap", 0, 0, '0, 1);
    chk("wrap_pcif", PC_IF, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset mid-wait
    step("mw", 0, 0, '0, 0);
    #2;
    do_reset();
    step("rs0", 0, 0, '0, 1);
    chk("rs_addr", imem_addr, RPC);

    // Randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom();
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | {28'd0, t[3:0]};
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), t,
           ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
